sccb_init_sequencer: RTL and testbench
======================================

Name: sccb_init_sequencer

Overview:
- Sequences camera bring-up for the SCCB master.
- Drives the camera power-down and reset pins through the power-up timing.
- Walks a register table in an external synchronous ROM and issues one SCCB write per entry through a req/ack handshake to the existing SCCB master (the block that drives sio_c/sio_d).
- Reports busy/done/error status; done/error are suitable for the board LEDs.

Parameters:
- MS_CYCLES, 50000: clk cycles per millisecond.
- ROM_AW, 8: ROM address width; the table holds 2**ROM_AW entries.
- DEV_ID, 8'h42: SCCB write device ID presented with every request.
- RST_MS, 1: duration, in ms, that cam_rst_n is held low after start.
- BOOT_MS, 1: wait, in ms, after cam_rst_n rises before the first write.
- MAX_RETRY, 3: retries allowed after a NACK before raising error.
- RETRY_MS, 1: gap, in ms, between a NACK and the next attempt.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins the sequence.
- rom_addr  out  ROM_AW  table read address.
- rom_data  in  16  {reg[15:8], val[7:0]}; valid 1 cycle after rom_addr.
- sccb_req  out  1  write request to the SCCB master.
- sccb_dev_id  out  8  device ID; constant DEV_ID.
- sccb_reg  out  8  register address.
- sccb_wdata  out  8  register value.
- sccb_ack  in  1  1-cycle pulse: write completed and ACKed.
- sccb_nack  in  1  1-cycle pulse: write completed with a NACK.
- cam_pwdn  out  1  camera power-down, active-high.
- cam_rst_n  out  1  camera reset, active-low.
- busy  out  1  sequence in progress.
- done  out  1  sequence completed; sticky.
- error  out  1  retry limit exceeded; sticky.
- err_index  out  ROM_AW  table index of the failing entry.

Behaviour:
- Reset values: cam_pwdn=1, cam_rst_n=0, sccb_req=0, sccb_reg=0, sccb_wdata=0, rom_addr=0, busy=0, done=0, error=0, err_index=0. State returns to IDLE. Reset asserted mid-transfer aborts it: sccb_req is 0 in the cycle after rst is sampled.
- States: IDLE, RST_HOLD, BOOT_WAIT, FETCH, DECODE, WRITE, DELAY, RETRY_WAIT, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - go to RST_HOLD; clear done/error; busy=1; cam_pwdn=0; cam_rst_n=0; rom_addr=0; retry count=0.
  - start is ignored in every other state.
- RST_HOLD: lasts RST_MS*MS_CYCLES cycles, then cam_rst_n=1 and go to BOOT_WAIT.
- BOOT_WAIT: lasts BOOT_MS*MS_CYCLES cycles, then FETCH.
- FETCH: presents rom_addr; exactly 1 cycle; go to DECODE.
- DECODE: samples rom_data. Entries are decoded in this order:
  - reg=8'hFF and val=8'hFF: end marker; go to DONE.
  - reg=8'hF0: delay; go to DELAY for val*MS_CYCLES cycles. val=0 means no wait (straight to advance).
  - otherwise: latch sccb_reg/sccb_wdata, assert sccb_req, go to WRITE.
- WRITE:
  - sccb_req is held high with stable payload until sccb_ack or sccb_nack is sampled. The master pulses ack/nack no earlier than the cycle after req rises.
  - On ack: req=0 the next cycle, retry count=0, advance.
  - On nack with retry count < MAX_RETRY: req=0, increment retry count, go to RETRY_WAIT (RETRY_MS*MS_CYCLES cycles), then reassert req with the same payload.
  - On nack with retry count = MAX_RETRY: req=0, error=1, err_index=rom_addr, busy=0, go to ERROR.
  - ack and nack sampled in the same cycle are treated as nack.
- Advance:
  - If rom_addr = 2**ROM_AW-1, go to DONE; the address never wraps.
  - Otherwise increment rom_addr and go to FETCH.
- DONE: done=1, busy=0. cam_pwdn/cam_rst_n stay at 0/1.
- ERROR: cam pins unchanged; no further requests are issued.
- Per-write overhead (FETCH + DECODE) is 2 cycles before sccb_req rises.
- Millisecond counts use a counter wide enough for 255*MS_CYCLES.

Decomposition:
- sccb_pkg holds:
  - the state enum;
  - constants SCCB_REG_END=8'hFF, SCCB_VAL_END=8'hFF, SCCB_REG_DELAY=8'hF0;
  - default SCCB_DEV_ID=8'h42.
- One sub-module, sccb_ms_timer: a loadable countdown taking an ms count and MS_CYCLES, with an expired output. It is shared by RST_HOLD, BOOT_WAIT, DELAY and RETRY_WAIT.
- The ROM is external to this block.

Test Plan:
All scenarios use MS_CYCLES=4, RST_MS=1, BOOT_MS=1, RETRY_MS=1, MAX_RETRY=3. The master model acks 3 cycles after req unless stated otherwise.
- Basic sequence. ROM {12 80},{F0 02},{11 01},{FF FF}, then start:
  - cam_pwdn falls; cam_rst_n low 4 cycles, then high; 4 cycles later the first req carries reg 12 / data 80.
  - After ack, 8 cycles pass with no req, then reg 11 / data 01.
  - After that ack: done=1, busy=0, exactly 2 requests in total.
- Retry recovers. First entry NACKed twice, ACKed on the third attempt:
  - 3 req assertions with identical payload, 4-cycle gaps between them.
  - done=1, error=0.
- Retry exhausted. First entry NACKed 4 times:
  - error=1, err_index=0, done=0, busy=0.
  - No further req for 100 cycles.
- Start handling:
  - start pulsed during WRITE: ignored, and the request count is unchanged.
  - start after DONE: done clears the next cycle and the full sequence repeats identically.
- Reset mid-transfer. rst asserted while sccb_req=1:
  - next cycle sccb_req=0, cam_pwdn=1, cam_rst_n=0, busy=0.
  - a later start reruns the sequence from index 0.
- No end marker. ROM_AW=2, all 4 entries are writes:
  - exactly 4 requests at indices 0..3, then done=1.
  - rom_addr stays at 3 and never wraps to 0.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and table-decode constants for the SCCB camera init sequencer.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_RST_HOLD   = 4'd1,
    ST_BOOT_WAIT  = 4'd2,
    ST_FETCH      = 4'd3,
    ST_DECODE     = 4'd4,
    ST_WRITE      = 4'd5,
    ST_DELAY      = 4'd6,
    ST_RETRY_WAIT = 4'd7,
    ST_DONE       = 4'd8,
    ST_ERROR      = 4'd9
  } sccb_state_e;

  localparam logic [7:0] SCCB_REG_END   = 8'hFF;
  localparam logic [7:0] SCCB_VAL_END   = 8'hFF;
  localparam logic [7:0] SCCB_REG_DELAY = 8'hF0;
  localparam logic [7:0] SCCB_DEV_ID    = 8'h42;

endpackage

// File: rtl/sccb_ms_timer.sv
// Loadable millisecond countdown; expired is high in the last cycle of the interval.
module sccb_ms_timer #(
  parameter int MS_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] ms,
  output logic       expired
);

  localparam int CNT_W = $clog2(255 * MS_CYCLES + 1);

  logic [CNT_W-1:0] count_r;

  // Load ms*MS_CYCLES, then count down to zero and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_W'(0);
    end else if (load) begin
      count_r <= CNT_W'(ms) * CNT_W'(MS_CYCLES);
    end else if (count_r != CNT_W'(0)) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Flag one cycle early so a state loaded with N lasts exactly N cycles.
  assign expired = (count_r <= CNT_W'(1));

endmodule

// File: rtl/sccb_init_sequencer.sv
// Camera bring-up: power/reset pin timing, then one SCCB write per ROM table entry.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter int         MS_CYCLES = 50000,
  parameter int         ROM_AW    = 8,
  parameter logic [7:0] DEV_ID    = SCCB_DEV_ID,
  parameter int         RST_MS    = 1,
  parameter int         BOOT_MS   = 1,
  parameter int         MAX_RETRY = 3,
  parameter int         RETRY_MS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_req,
  output logic [7:0]        sccb_dev_id,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_wdata,
  input  logic              sccb_ack,
  input  logic              sccb_nack,
  output logic              cam_pwdn,
  output logic              cam_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ROM_AW-1:0] err_index
);

  sccb_state_e       state_r, adv_state_s;
  logic [ROM_AW-1:0] rom_addr_r, adv_addr_s, err_index_r;
  logic [7:0]        retry_r, reg_r, wdata_r, tmr_ms_s;
  logic              req_r, pwdn_r, rst_n_r, busy_r, done_r, error_r;
  logic              tmr_load_s, tmr_expired_s, at_last_s, is_end_s, is_delay_s;

  assign is_end_s   = (rom_data[15:8] == SCCB_REG_END) && (rom_data[7:0] == SCCB_VAL_END);
  assign is_delay_s = (rom_data[15:8] == SCCB_REG_DELAY);
  assign at_last_s  = (rom_addr_r == {ROM_AW{1'b1}});

  // Next index after a completed entry; the last table slot finishes instead of wrapping.
  always_comb begin
    adv_state_s = ST_FETCH;
    adv_addr_s  = rom_addr_r + ROM_AW'(1);
    if (at_last_s) begin
      adv_state_s = ST_DONE;
      adv_addr_s  = rom_addr_r;
    end else begin
      adv_state_s = ST_FETCH;
      adv_addr_s  = rom_addr_r + ROM_AW'(1);
    end
  end

  // Select which interval, if any, the shared timer starts this cycle.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_ms_s   = 8'd0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          tmr_load_s = 1'b1;
          tmr_ms_s   = 8'(RST_MS);
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_RST_HOLD: begin
        if (tmr_expired_s) begin
          tmr_load_s = 1'b1;
          tmr_ms_s   = 8'(BOOT_MS);
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_DECODE: begin
        if (!is_end_s && is_delay_s) begin
          tmr_load_s = 1'b1;
          tmr_ms_s   = rom_data[7:0];
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_WRITE: begin
        if (sccb_nack && (retry_r < 8'(MAX_RETRY))) begin
          tmr_load_s = 1'b1;
          tmr_ms_s   = 8'(RETRY_MS);
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      default: begin
        tmr_load_s = 1'b0;
        tmr_ms_s   = 8'd0;
      end
    endcase
  end

  sccb_ms_timer #(.MS_CYCLES(MS_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load_s),
    .ms      (tmr_ms_s),
    .expired (tmr_expired_s)
  );

  // Sequencer state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rom_addr_r  <= '0;
      err_index_r <= '0;
      retry_r     <= 8'd0;
      reg_r       <= 8'd0;
      wdata_r     <= 8'd0;
      req_r       <= 1'b0;
      pwdn_r      <= 1'b1;
      rst_n_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_r    <= ST_RST_HOLD;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b1;
            pwdn_r     <= 1'b0;
            rst_n_r    <= 1'b0;
            rom_addr_r <= '0;
            retry_r    <= 8'd0;
          end
        end
        ST_RST_HOLD: begin
          if (tmr_expired_s) begin
            rst_n_r <= 1'b1;
            state_r <= ST_BOOT_WAIT;
          end
        end
        ST_BOOT_WAIT: begin
          if (tmr_expired_s) begin
            state_r <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_r <= ST_DECODE;
        end
        ST_DECODE: begin
          if (is_end_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else if (is_delay_s) begin
            if (rom_data[7:0] == 8'd0) begin
              state_r    <= adv_state_s;
              rom_addr_r <= adv_addr_s;
              done_r     <= at_last_s;
              busy_r     <= ~at_last_s;
            end else begin
              state_r <= ST_DELAY;
            end
          end else begin
            reg_r   <= rom_data[15:8];
            wdata_r <= rom_data[7:0];
            req_r   <= 1'b1;
            state_r <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // A simultaneous ack and nack counts as a NACK.
          if (sccb_nack) begin
            req_r <= 1'b0;
            if (retry_r < 8'(MAX_RETRY)) begin
              retry_r <= retry_r + 8'd1;
              state_r <= ST_RETRY_WAIT;
            end else begin
              error_r     <= 1'b1;
              err_index_r <= rom_addr_r;
              busy_r      <= 1'b0;
              state_r     <= ST_ERROR;
            end
          end else if (sccb_ack) begin
            req_r      <= 1'b0;
            retry_r    <= 8'd0;
            state_r    <= adv_state_s;
            rom_addr_r <= adv_addr_s;
            done_r     <= at_last_s;
            busy_r     <= ~at_last_s;
          end
        end
        ST_DELAY: begin
          if (tmr_expired_s) begin
            state_r    <= adv_state_s;
            rom_addr_r <= adv_addr_s;
            done_r     <= at_last_s;
            busy_r     <= ~at_last_s;
          end
        end
        ST_RETRY_WAIT: begin
          if (tmr_expired_s) begin
            req_r   <= 1'b1;
            state_r <= ST_WRITE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr    = rom_addr_r;
  assign sccb_req    = req_r;
  assign sccb_dev_id = DEV_ID;
  assign sccb_reg    = reg_r;
  assign sccb_wdata  = wdata_r;
  assign cam_pwdn    = pwdn_r;
  assign cam_rst_n   = rst_n_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;
  assign err_index   = err_index_r;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: 4-entry ROM model, scripted SCCB master, scenario table.
module tb_sccb_init_sequencer;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          log_clr = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0000;
  logic          sccb_req;
  logic [7:0]    sccb_dev_id, sccb_reg, sccb_wdata;
  logic          sccb_ack = 1'b0;
  logic          sccb_nack = 1'b0;
  logic          cam_pwdn, cam_rst_n, busy, done, error;
  logic [AW-1:0] err_index;

  sccb_init_sequencer #(
    .MS_CYCLES(4), .ROM_AW(AW), .DEV_ID(8'h42), .RST_MS(1), .BOOT_MS(1),
    .MAX_RETRY(3), .RETRY_MS(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_req(sccb_req), .sccb_dev_id(sccb_dev_id), .sccb_reg(sccb_reg),
    .sccb_wdata(sccb_wdata), .sccb_ack(sccb_ack), .sccb_nack(sccb_nack),
    .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .busy(busy), .done(done),
    .error(error), .err_index(err_index)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [4];
  int   nack_total = 0;
  int   cyc = 0, req_n = 0, nack_given = 0, wait_cnt = 0;
  int   rstn_rise_cyc = 0, start_cyc = 0, fall_cyc = 0;
  logic req_q = 1'b0, rstn_q = 1'b0;
  int   rise_cyc [16];
  int   rise_gap [16];
  logic [7:0] rise_reg [16];
  logic [7:0] rise_val [16];
  int   n_cmp = 0, n_err = 0;

  // ROM, SCCB master (ack/nack 3 cycles after req rises) and event log.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    sccb_ack  <= 1'b0;
    sccb_nack <= 1'b0;
    req_q     <= sccb_req;
    rstn_q    <= cam_rst_n;
    rom_data  <= rom[rom_addr];
    if (log_clr) begin
      req_n      <= 0;
      nack_given <= 0;
      start_cyc  <= cyc;
    end else if (sccb_req && !req_q) begin
      if (req_n < 16) begin
        rise_cyc[req_n] <= cyc;
        rise_gap[req_n] <= cyc - fall_cyc;
        rise_reg[req_n] <= sccb_reg;
        rise_val[req_n] <= sccb_wdata;
      end
      req_n <= req_n + 1;
    end
    if (rst) begin
      wait_cnt <= 0;
    end else if (sccb_req && !req_q) begin
      wait_cnt <= 2;
    end else if (wait_cnt == 1) begin
      wait_cnt <= 0;
      if (nack_given < nack_total) begin
        sccb_nack  <= 1'b1;
        nack_given <= nack_given + 1;
      end else begin
        sccb_ack <= 1'b1;
      end
    end else if (wait_cnt > 1) begin
      wait_cnt <= wait_cnt - 1;
    end
    if (!sccb_req && req_q) fall_cyc <= cyc;
    if (cam_rst_n && !rstn_q) rstn_rise_cyc <= cyc;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_rom(input logic [3:0][15:0] r);
    for (int i = 0; i < 4; i++) rom[i] = r[i];
  endtask

  task automatic do_start();
    start = 1'b1; log_clr = 1'b1;
    @(negedge clk);
    start = 1'b0; log_clr = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sccb_req) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [3:0][15:0] rom;   // index 3 is leftmost
    int   nacks;
    int   reqs;
    logic exp_done;
    logic exp_err;
    int   err_idx;
    int   addr;
  } vec_t;

  vec_t vt [7];
  localparam logic [3:0][15:0] BASIC = {16'hFFFF, 16'h1101, 16'hF002, 16'h1280};

  initial begin
    bit ok;
    int hi;
    vt[0] = '{BASIC, 0, 2, 1'b1, 1'b0, 0, 3};
    vt[1] = '{BASIC, 2, 4, 1'b1, 1'b0, 0, 3};
    vt[2] = '{BASIC, 4, 4, 1'b0, 1'b1, 0, 0};
    vt[3] = '{{16'h0D44, 16'h0C33, 16'h0B22, 16'h0A11}, 0, 4, 1'b1, 1'b0, 0, 3};
    vt[4] = '{{16'h0000, 16'hFFFF, 16'h2055, 16'hF000}, 4, 4, 1'b0, 1'b1, 1, 1};
    vt[5] = '{{16'h0000, 16'hFFFF, 16'h3344, 16'hFF00}, 0, 2, 1'b1, 1'b0, 0, 2};
    vt[6] = '{{16'h1111, 16'h1111, 16'h1111, 16'hFFFF}, 0, 0, 1'b1, 1'b0, 0, 0};
    load_rom(BASIC);

    repeat (3) @(negedge clk);
    chk("rst_pwdn", 32'(cam_pwdn), 1);
    chk("rst_rstn", 32'(cam_rst_n), 0);
    chk("rst_req", 32'(sccb_req), 0);
    chk("rst_busy_done_err", {busy, done, error}, 0);
    chk("rst_payload", {sccb_reg, sccb_wdata, 6'(rom_addr), 6'(err_index)}, 0);
    chk("dev_id", 32'(sccb_dev_id), 32'h42);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      load_rom(vt[v].rom);
      nack_total = vt[v].nacks;
      do_start();
      wait_end(3000, ok);
      chk($sformatf("v%0d_timeout", v), 32'(ok), 1);
      chk($sformatf("v%0d_reqs", v), req_n, vt[v].reqs);
      chk($sformatf("v%0d_done", v), 32'(done), 32'(vt[v].exp_done));
      chk($sformatf("v%0d_error", v), 32'(error), 32'(vt[v].exp_err));
      chk($sformatf("v%0d_busy", v), 32'(busy), 0);
      chk($sformatf("v%0d_addr", v), 32'(rom_addr), vt[v].addr);
      if (vt[v].exp_err) chk($sformatf("v%0d_err_idx", v), 32'(err_index), vt[v].err_idx);
    end

    // Basic timing, also restarting from DONE: done clears on the cycle after start.
    load_rom(BASIC);
    nack_total = 0;
    do_start();
    chk("t_start_state", {cam_pwdn, cam_rst_n, busy, done}, 4'b0010);
    wait_end(3000, ok);
    chk("t_timeout", 32'(ok), 1);
    // rise is logged one edge late, so 4 low cycles show as 5.
    chk("t_rstn_low", rstn_rise_cyc - start_cyc, 5);
    // 4 boot cycles + FETCH + DECODE.
    chk("t_first_req", rise_cyc[0] - rstn_rise_cyc, 6);
    chk("t_req0_payload", {rise_reg[0], rise_val[0]}, 16'h1280);
    // FETCH+DECODE, 8 delay cycles, FETCH+DECODE.
    chk("t_delay_gap", rise_gap[1], 12);
    chk("t_req1_payload", {rise_reg[1], rise_val[1]}, 16'h1101);
    chk("t_reqs", req_n, 2);
    chk("t_end_pins", {cam_pwdn, cam_rst_n, done, busy}, 4'b0110);

    // Retry recovers: identical payload, 4-cycle gaps.
    nack_total = 2;
    do_start();
    wait_end(3000, ok);
    chk("r_timeout", 32'(ok), 1);
    for (int i = 1; i < 3; i++) begin
      chk($sformatf("r_gap%0d", i), rise_gap[i], 4);
      chk($sformatf("r_payload%0d", i), {rise_reg[i], rise_val[i]}, 16'h1280);
    end
    chk("r_next_entry", {rise_reg[3], rise_val[3]}, 16'h1101);
    chk("r_done_err", {done, error}, 2'b10);

    // Retry exhausted: nothing further for 100 cycles, cam pins unchanged.
    nack_total = 4;
    do_start();
    wait_end(3000, ok);
    chk("e_timeout", 32'(ok), 1);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sccb_req) hi++;
    end
    chk("e_req_high", hi, 0);
    chk("e_reqs", req_n, 4);
    chk("e_state", {error, done, busy, cam_pwdn, cam_rst_n}, 5'b10001);

    // Start during WRITE is ignored.
    nack_total = 0;
    do_start();
    wait_req(100, ok);
    chk("s_req_seen", 32'(ok), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s_busy", 32'(busy), 1);
    chk("s_req_held", 32'(sccb_req), 1);
    wait_end(3000, ok);
    chk("s_timeout", 32'(ok), 1);
    chk("s_reqs", req_n, 2);
    chk("s_done", 32'(done), 1);

    // Reset while a request is outstanding, then rerun from index 0.
    do_start();
    wait_req(100, ok);
    chk("x_req_seen", 32'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("x_after_rst", {sccb_req, cam_pwdn, cam_rst_n, busy, done}, 5'b01000);
    chk("x_addr", 32'(rom_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    wait_end(3000, ok);
    chk("x_timeout", 32'(ok), 1);
    chk("x_first", {rise_reg[0], rise_val[0]}, 16'h1280);
    chk("x_reqs", req_n, 2);
    chk("x_done", 32'(done), 1);

    // No end marker: all four entries written, address holds at 3.
    load_rom(vt[3].rom);
    do_start();
    wait_end(3000, ok);
    chk("w_timeout", 32'(ok), 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("w_payload%0d", i), {rise_reg[i], rise_val[i]}, 32'(vt[3].rom[i]));
    repeat (10) @(negedge clk);
    chk("w_addr_hold", 32'(rom_addr), 3);
    chk("w_reqs", req_n, 4);
    chk("w_done", 32'(done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
